bit_counter_param: RTL and testbench
====================================

# bit_counter_param

Parametrised population counter that counts the ones (or zeros) in a DATA_W-bit word, scanning STEP bits per clock.
- Terminates early once no counted bits remain.
- Reports the result through a start/busy/done handshake.
- Serves as the generalised successor of the fixed 16-bit ones-counter FSM.
- Sits beside the datapath blocks that need a bit-weight of a captured operand without a full combinational adder tree.

## Interface
- DATA_W, 16, operand width; ≥ 2.
- STEP, 1, bits examined per cycle. Must divide DATA_W; 1 ≤ STEP ≤ DATA_W.
- CNT_W (localparam), $clog2(DATA_W+1), result width (5 for DATA_W=16).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_  input  1  reset; one clock; reset is synchronous and active-low.
- i_start  input  1  request; sampled only while o_busy=0.
- i_mode  input  1  0 = count ones, 1 = count zeros; sampled with i_start.
- i_data  input  DATA_W  operand; sampled with i_start.
- o_busy  output  1  high while scanning.
- o_done  output  1  one-cycle pulse; o_count valid from this cycle.
- o_count  output  CNT_W  result; held until the next accepted start.

## Operation
- States:
  - IDLE: reset state.
  - SCAN: counting.
  - DONE: single-cycle result strobe.
- Registers:
  - shift register sr[DATA_W-1:0]
  - accumulator cnt[CNT_W-1:0]
  - state
- Start acceptance: an edge with i_start=1 in IDLE or DONE accepts the request.
  - sr ← i_mode ? ~i_data : i_data.
  - cnt ← 0.
  - state ← SCAN.
- i_start in SCAN is ignored; the operand is not queued.
- SCAN, each edge:
  - cnt ← cnt + popcount(sr[STEP-1:0]).
  - sr ← sr >> STEP, zero-filled.
  - If (sr >> STEP) == 0, state ← DONE; otherwise stay in SCAN.
- DONE: o_done=1.
  - Next state is SCAN if i_start=1 (back-to-back request), else IDLE.
- Outputs:
  - o_busy = (state==SCAN).
  - o_done = (state==DONE).
  - o_count = cnt, driven at all times (no tri-state).
- Arithmetic:
  - Unsigned arithmetic throughout.
  - cnt never exceeds DATA_W, so no overflow is possible at width CNT_W.
- Mode 1 counts zeros of the original word via inversion. Early termination therefore applies to the highest original zero bit.

## Timing
- Reset: on an edge with i_rst_=0, regardless of state:
  - state=IDLE, sr=0, cnt=0.
  - o_busy=0, o_done=0, o_count=0.
- Reset mid-SCAN aborts the operation with no o_done pulse.
- Reset has priority over i_start on the same edge.
- Definitions:
  - h = index of the highest counted bit + 1 (0 if none).
  - N = max(1, ceil(h/STEP)).
- Latency, taking the i_start cycle as cycle 0:
  - o_busy=1 in cycles 1..N.
  - o_done=1 in cycle N+1.
  - o_count is final in cycle N+1.
- Bounds:
  - Worst case: N = DATA_W/STEP.
  - Best case (no counted bits): N=1, o_done in cycle 2.
- Back-to-back: a start in the DONE cycle yields o_busy=1 in the next cycle. No idle bubble; throughput is N+1 cycles per operand.
- o_count changes only during SCAN. After o_done it is stable until the next accepted start, at which point it clears to 0 on that edge.

## Test plan
- Reset: hold i_rst_=0 for 2 cycles with i_start=1 and random i_data -> o_busy=0, o_done=0, o_count=0 throughout; no operation starts.
- DATA_W=16, STEP=1, i_mode=0, i_data=16'hF00F -> o_busy cycles 1..16, o_done in cycle 17, o_count=8. Repeat with 16'h0013 -> o_count=3, o_done in cycle 6 (early stop).
- Edge operands, STEP=1:
  - i_mode=0, i_data=16'h0000 -> o_count=0, o_done in cycle 2.
  - i_mode=1, i_data=16'hFFFF -> same.
  - i_mode=0, i_data=16'hFFFF -> o_count=16 (5'b10000), o_done in cycle 17.
- Zero counting and STEP:
  - i_mode=1, i_data=16'h00F0, STEP=1 -> o_count=12, o_done in cycle 17.
  - STEP=4, i_mode=0, i_data=16'h0013 -> o_count=3, o_done in cycle 3.
- Handshake:
  - i_start pulses during SCAN are ignored and the result is unchanged.
  - i_start in the DONE cycle with 16'h0001 -> o_busy next cycle, o_count=1 two cycles later.
  - i_rst_=0 in cycle 5 of a scan -> IDLE, o_count=0, no o_done.

Source files
------------

// File: rtl/bit_counter_param.sv
// bit_counter_param: sequential population counter over a DATA_W-bit operand.
// Counts ones (i_mode=0) or zeros (i_mode=1) of the captured word, examining
// STEP bits per clock and finishing as soon as no counted bits remain.
// Handshake: i_start accepted outside SCAN, o_busy while scanning, o_done
// for one cycle with o_count valid from then until the next accepted start.
module bit_counter_param #(
  parameter int  DATA_W = 16,
  parameter int  STEP   = 1,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] sr_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  step_pop;
  logic              busy_q, done_q;

  // Remaining operand after this cycle's slice has been consumed.
  assign sr_shift = sr_q >> STEP;

  // Number of set bits in the STEP-bit slice examined this cycle.
  always_comb begin
    step_pop = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      step_pop = step_pop + CNT_W'(sr_q[i]);
    end
  end

  // Next-state logic: load on an accepted start, accumulate while scanning.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        // A start in DONE goes straight back to SCAN, so back-to-back
        // operands see no idle bubble.
        if (i_start) begin
          sr_d    = i_mode ? ~i_data : i_data;
          cnt_d   = '0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + step_pop;
        sr_d  = sr_shift;
        if (sr_shift == '0) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == SCAN);
      done_q  <= (state_d == DONE);
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_bit_counter_param.sv
// Scoreboard bench for bit_counter_param: one instance with STEP=1 and one
// with STEP=4. Stimulus pushes hand-computed results; per-instance monitors
// pop and compare on every o_done and check o_count holds while idle.
module tb_bit_counter_param;

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef struct {
    logic [CNT_W-1:0] cnt;
    int unsigned      done_cyc;
    int unsigned      start_cyc;
  } exp_t;

  typedef struct {
    logic        m;
    logic [15:0] d;
    int unsigned c;
    int unsigned d1;
    int unsigned d4;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_;
  logic              start [2];
  logic              mode  [2];
  logic [DATA_W-1:0] data  [2];
  logic              busy  [2];
  logic              done  [2];
  logic [CNT_W-1:0]  count [2];

  int unsigned       cyc = 0;
  int                checks = 0;
  int                passes = 0;
  exp_t              q0[$];
  exp_t              q1[$];
  int unsigned       busy_n [2];
  logic [CNT_W-1:0]  hold   [2];

  // mode, data, count, done cycle at STEP=1, done cycle at STEP=4
  vec_t vt [10] = '{
    '{1'b0, 16'hF00F,  8, 17, 5},
    '{1'b0, 16'h0013,  3,  6, 3},
    '{1'b0, 16'h0000,  0,  2, 2},
    '{1'b1, 16'hFFFF,  0,  2, 2},
    '{1'b0, 16'hFFFF, 16, 17, 5},
    '{1'b1, 16'h00F0, 12, 17, 5},
    '{1'b1, 16'h8000, 15, 16, 5},
    '{1'b0, 16'h8000,  1, 17, 5},
    '{1'b0, 16'h0001,  1,  2, 2},
    '{1'b0, 16'h0010,  1,  6, 3}
  };

  bit_counter_param #(.DATA_W(DATA_W), .STEP(1)) u_s1 (
    .i_clk   (clk),
    .i_rst_  (rst_),
    .i_start (start[0]),
    .i_mode  (mode[0]),
    .i_data  (data[0]),
    .o_busy  (busy[0]),
    .o_done  (done[0]),
    .o_count (count[0])
  );

  bit_counter_param #(.DATA_W(DATA_W), .STEP(4)) u_s4 (
    .i_clk   (clk),
    .i_rst_  (rst_),
    .i_start (start[1]),
    .i_mode  (mode[1]),
    .i_data  (data[1]),
    .o_busy  (busy[1]),
    .o_done  (done[1]),
    .o_count (count[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int unsigned qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor for instance s, sampled on the falling edge.
  task automatic mon(input int s);
    exp_t  e;
    string tag;
    tag = (s == 0) ? "s1" : "s4";
    if (!rst_) begin
      if (s == 0) q0.delete(); else q1.delete();
      busy_n[s] = 0;
      hold[s]   = '0;
      return;
    end
    if (busy[s]) busy_n[s]++;
    if (done[s]) begin
      if (qsize(s) == 0) begin
        chk({tag, " unexpected_done"}, 32'(done[s]), 32'd0);
        hold[s] = count[s];
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        chk({tag, " count"},      32'(count[s]), 32'(e.cnt));
        chk({tag, " done_cycle"}, cyc - e.start_cyc, e.done_cyc);
        chk({tag, " busy_cycles"}, busy_n[s], e.done_cyc - 1);
        hold[s] = e.cnt;
      end
      busy_n[s] = 0;
    end else if (!busy[s]) begin
      chk({tag, " idle_hold"}, 32'(count[s]), 32'(hold[s]));
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Drive one start cycle (called just after a rising edge); returns in cycle 1.
  task automatic issue(input int s, input logic m, input logic [15:0] d,
                       input int unsigned ec, input int unsigned ed);
    exp_t e;
    start[s]    = 1'b1;
    mode[s]     = m;
    data[s]     = d;
    e.cnt       = CNT_W'(ec);
    e.done_cyc  = ed;
    e.start_cyc = cyc;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    start[s] = 1'b0;
    mode[s]  = 1'($urandom);
    data[s]  = 16'($urandom);
  endtask

  task automatic wait_idle(input int s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (qsize(s) == 0 && !busy[s] && !done[s]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk((s == 0) ? "s1 timeout" : "s4 timeout", qsize(s), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_  = 1'b0;
    start = '{1'b1, 1'b1};
    mode  = '{1'b0, 1'b1};
    data[0] = 16'($urandom);
    data[1] = 16'($urandom);

    // Reset held two edges with start asserted: nothing may begin.
    repeat (2) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        chk("rst busy",  32'(busy[s]),  32'd0);
        chk("rst done",  32'(done[s]),  32'd0);
        chk("rst count", 32'(count[s]), 32'd0);
      end
    end
    rst_  = 1'b1;
    start = '{1'b0, 1'b0};
    @(posedge clk); #1;
    chk("post_rst busy", 32'(busy[0]), 32'd0);

    // Directed vectors on both step sizes.
    foreach (vt[k]) begin
      issue(0, vt[k].m, vt[k].d, vt[k].c, vt[k].d1);
      wait_idle(0);
    end
    foreach (vt[k]) begin
      issue(1, vt[k].m, vt[k].d, vt[k].c, vt[k].d4);
      wait_idle(1);
    end

    // Starts during SCAN are ignored.
    issue(0, 1'b0, 16'hF00F, 8, 17);
    repeat (3) begin @(posedge clk); #1; end
    start[0] = 1'b1; mode[0] = 1'b1; data[0] = 16'hFFFF;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start[0] = 1'b1; mode[0] = 1'b0; data[0] = 16'h0000;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_idle(0);

    // Back-to-back start in the DONE cycle.
    issue(0, 1'b0, 16'h0013, 3, 6);
    for (int i = 0; i < 30; i++) begin
      if (done[0]) break;
      @(posedge clk); #1;
    end
    if (!done[0]) begin
      chk("s1 b2b_wait_done", 32'(done[0]), 32'd1);
    end else begin
      issue(0, 1'b0, 16'h0001, 1, 2);
      chk("s1 b2b_busy_next", 32'(busy[0]), 32'd1);
    end
    wait_idle(0);

    // Reset in cycle 5 of a scan aborts with no done pulse.
    issue(0, 1'b0, 16'hFFFF, 16, 17);
    repeat (4) begin @(posedge clk); #1; end
    rst_ = 1'b0;
    @(posedge clk); #1;
    rst_ = 1'b1;
    chk("abort busy",  32'(busy[0]),  32'd0);
    chk("abort done",  32'(done[0]),  32'd0);
    chk("abort count", 32'(count[0]), 32'd0);
    repeat (20) begin @(posedge clk); #1; end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
